fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction memory. It owns the program counter and drives pc_addr to the memory, which returns the instruction combinationally.
- Captures instruction, PC and memory fault status into the IF/ID pipeline register consumed by decode.
- Handles stall, branch/jump redirect, trap redirect, and instruction-access / misaligned fetch faults. After a fault it parks until a trap redirect arrives.

Parameters:
- RESET_PC, 64'h0000_0000_0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word placed in IF/ID on bubbles and faults (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall_i  input  1  downstream stall; hold PC and IF/ID.
- redirect_en  input  1  branch/jump taken, resolved in execute.
- redirect_pc  input  64  branch/jump target.
- trap_en  input  1  trap entry or mret from CSR unit.
- trap_pc  input  64  trap vector or mepc.
- pc_addr  output  64  current PC to instruction memory; equals the PC register.
- imem_instr  input  32  instruction returned for pc_addr.
- imem_exc_en  input  1  memory access fault for pc_addr.
- imem_exc_code  input  4  memory fault cause.
- imem_exc_val  input  64  memory fault address.
- id_valid  output  1  IF/ID entry holds a real instruction or fault.
- id_pc  output  64  PC of the IF/ID entry.
- id_instr  output  32  instruction word of the IF/ID entry.
- id_exc_en  output  1  IF/ID entry carries a fetch fault.
- id_exc_code  output  4  fault cause: 0 = misaligned, 1 = access fault.
- id_exc_val  output  64  faulting address, written to mtval by the CSR unit.

Behaviour:
- Reset: on rst_n low, immediately set:
  - pc = RESET_PC, state = RUN
  - id_valid = 0, id_pc = 0, id_instr = NOP_INSTR
  - id_exc_en = 0, id_exc_code = 0, id_exc_val = 0
  - Reset asserted mid-operation discards all in-flight state.
- States: RUN (fetching), PARKED (fault delivered, waiting for trap redirect).
- Per-edge priority: trap_en > redirect_en > stall_i > normal.
- trap_en (either state):
  - pc <= {trap_pc[63:2], 2'b00}; the low bits are forced to zero, so no misaligned fault is raised.
  - IF/ID flushed to reset values; state <= RUN.
  - Overrides stall_i.
- redirect_en (RUN only; ignored in PARKED):
  - IF/ID flushed and stall_i overridden.
  - If redirect_pc[1:0] == 0: pc <= redirect_pc, state stays RUN.
  - Else: pc <= redirect_pc (held), next non-stalled edge loads IF/ID with valid=1, pc=redirect_pc, instr=NOP_INSTR, exc_en=1, code=0, val=redirect_pc; state <= PARKED at that edge. The memory is not consulted for the misaligned PC.
- stall_i (no redirect/trap): pc, IF/ID and state all held.
- Normal RUN edge, imem_exc_en=0:
  - IF/ID <= {valid=1, pc, imem_instr, exc=0}.
  - pc <= pc + 4, wrapping modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC -> 0).
  - Throughput: one instruction per cycle. Latency: the instruction at pc appears on id_* one edge after pc_addr presents it.
- Normal RUN edge, imem_exc_en=1:
  - IF/ID <= {valid=1, pc, NOP_INSTR, exc_en=1, imem_exc_code, imem_exc_val}.
  - pc held; state <= PARKED.
  - The fault is latched on the first cycle it is seen. imem_exc_en is not required to stay high.
- PARKED, non-stalled edge: IF/ID <= bubble (valid=0, NOP_INSTR, exc cleared) and pc held, so the fault entry is delivered exactly once. Stalled edges hold the fault entry.
- Simultaneous imem_exc_en with redirect/trap: the redirect/trap wins and the fault is dropped.
- No combinational path from stall_i, redirect_en or trap_en to pc_addr.

Test Plan:
- Reset release, RESET_PC=0, memory returns 0x00500093 at 0 and 0x00a00113 at 4, no stall -> edge1: id_pc=0, id_instr=0x00500093, valid=1; edge2: id_pc=4, id_instr=0x00a00113; pc_addr=8.
- stall_i high 3 cycles at pc=8 -> pc_addr stays 8, id_* unchanged for 3 edges; fetch resumes with id_pc=8 after stall drops.
- redirect_en with redirect_pc=0x40 while stall_i=1 -> next edge pc_addr=0x40, id_valid=0; following edge id_pc=0x40.
- redirect_pc=0x42 -> one edge later id_valid=1, id_exc_en=1, code=0, val=0x42, id_instr=0x13; next edge id_valid=0; pc_addr held at 0x42 until trap_en with trap_pc=0x100 -> pc_addr=0x100, state RUN.
- pc_addr=0x2000 and memory drives imem_exc_en=1, code=1, val=0x2000 for one cycle -> id_exc_en=1, code=1, val=0x2000 for one entry, then bubbles; pc held at 0x2000.
- rst_n pulsed low asynchronously mid-stream (pc=0x48, id_valid=1) -> pc_addr=RESET_PC and id_valid=0 before the next clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory and fills
// the IF/ID register, parking after a fetch fault until a trap redirect arrives.
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    input  logic        trap_en,
    input  logic [63:0] trap_pc,
    output logic [63:0] pc_addr,
    input  logic [31:0] imem_instr,
    input  logic        imem_exc_en,
    input  logic [3:0]  imem_exc_code,
    input  logic [63:0] imem_exc_val,
    output logic        id_valid,
    output logic [63:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_exc_en,
    output logic [3:0]  id_exc_code,
    output logic [63:0] id_exc_val
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PARKED = 1'b1
    } state_t;

    localparam logic [3:0] CODE_MISALIGNED = 4'd0;

    state_t      state_reg;
    logic [63:0] pc_reg;

    assign pc_addr = pc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_RUN;
            pc_reg      <= RESET_PC;
            id_valid    <= 1'b0;
            id_pc       <= 64'd0;
            id_instr    <= NOP_INSTR;
            id_exc_en   <= 1'b0;
            id_exc_code <= 4'd0;
            id_exc_val  <= 64'd0;
        end else if (trap_en) begin
            state_reg   <= ST_RUN;
            pc_reg      <= {trap_pc[63:2], 2'b00};
            id_valid    <= 1'b0;
            id_pc       <= 64'd0;
            id_instr    <= NOP_INSTR;
            id_exc_en   <= 1'b0;
            id_exc_code <= 4'd0;
            id_exc_val  <= 64'd0;
        end else if (redirect_en && state_reg == ST_RUN) begin
            // A misaligned target is loaded as-is; the RUN path below faults on it.
            pc_reg      <= redirect_pc;
            id_valid    <= 1'b0;
            id_pc       <= 64'd0;
            id_instr    <= NOP_INSTR;
            id_exc_en   <= 1'b0;
            id_exc_code <= 4'd0;
            id_exc_val  <= 64'd0;
        end else if (stall_i) begin
            // hold everything
        end else if (state_reg == ST_RUN) begin
            id_valid <= 1'b1;
            id_pc    <= pc_reg;
            if (pc_reg[1:0] != 2'b00) begin
                state_reg   <= ST_PARKED;
                id_instr    <= NOP_INSTR;
                id_exc_en   <= 1'b1;
                id_exc_code <= CODE_MISALIGNED;
                id_exc_val  <= pc_reg;
            end else if (imem_exc_en) begin
                state_reg   <= ST_PARKED;
                id_instr    <= NOP_INSTR;
                id_exc_en   <= 1'b1;
                id_exc_code <= imem_exc_code;
                id_exc_val  <= imem_exc_val;
            end else begin
                pc_reg      <= pc_reg + 64'd4;
                id_instr    <= imem_instr;
                id_exc_en   <= 1'b0;
                id_exc_code <= 4'd0;
                id_exc_val  <= 64'd0;
            end
        end else begin
            // Parked: the fault entry was delivered once, now feed bubbles.
            id_valid    <= 1'b0;
            id_instr    <= NOP_INSTR;
            id_exc_en   <= 1'b0;
            id_exc_code <= 4'd0;
            id_exc_val  <= 64'd0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus random checks of fetch_stage against a behavioural model of
// the PC / IF/ID rules, one comparison line per mismatch.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        trap_en;
    logic [63:0] trap_pc;
    logic [63:0] pc_addr;
    logic [31:0] imem_instr;
    logic        imem_exc_en;
    logic [3:0]  imem_exc_code;
    logic [63:0] imem_exc_val;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [31:0] id_instr;
    logic        id_exc_en;
    logic [3:0]  id_exc_code;
    logic [63:0] id_exc_val;

    int total = 0;
    int bad   = 0;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .trap_en(trap_en), .trap_pc(trap_pc), .pc_addr(pc_addr),
        .imem_instr(imem_instr), .imem_exc_en(imem_exc_en),
        .imem_exc_code(imem_exc_code), .imem_exc_val(imem_exc_val),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .id_exc_en(id_exc_en), .id_exc_code(id_exc_code), .id_exc_val(id_exc_val)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [63:0] a);
        if (a == 64'd0) return 32'h0050_0093;
        if (a == 64'd4) return 32'h00a0_0113;
        return a[31:0] ^ 32'h1234_5677 ^ {a[63:32]};
    endfunction

    assign imem_instr = mem(pc_addr);

    // reference model state
    logic [63:0] m_pc, m_id_pc, m_val;
    logic [31:0] m_instr;
    logic [3:0]  m_code;
    logic        m_valid, m_exc, m_parked;

    task automatic m_flush();
        m_valid = 0; m_id_pc = 0; m_instr = 32'h13; m_exc = 0; m_code = 0; m_val = 0;
    endtask

    task automatic m_reset();
        m_pc = 64'd0; m_parked = 0; m_flush();
    endtask

    task automatic m_fault(input logic [3:0] c, input logic [63:0] v);
        m_valid = 1; m_id_pc = m_pc; m_instr = 32'h13; m_exc = 1; m_code = c; m_val = v;
        m_parked = 1;
    endtask

    task automatic m_edge();
        if (trap_en) begin
            m_pc = trap_pc & ~64'd3; m_parked = 0; m_flush();
        end else if (redirect_en && !m_parked) begin
            m_pc = redirect_pc; m_flush();
        end else if (stall_i) begin
        end else if (!m_parked) begin
            if (m_pc % 4 != 0) m_fault(4'd0, m_pc);
            else if (imem_exc_en) m_fault(imem_exc_code, imem_exc_val);
            else begin
                m_valid = 1; m_id_pc = m_pc; m_instr = mem(m_pc); m_exc = 0; m_code = 0; m_val = 0;
                m_pc = m_pc + 64'd4;
            end
        end else begin
            m_valid = 0; m_instr = 32'h13; m_exc = 0; m_code = 0; m_val = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, " pc_addr"},  pc_addr,              m_pc);
        chk({where, " valid"},    {63'd0, id_valid},    {63'd0, m_valid});
        chk({where, " id_pc"},    id_pc,                m_id_pc);
        chk({where, " instr"},    {32'd0, id_instr},    {32'd0, m_instr});
        chk({where, " exc_en"},   {63'd0, id_exc_en},   {63'd0, m_exc});
        chk({where, " exc_code"}, {60'd0, id_exc_code}, {60'd0, m_code});
        chk({where, " exc_val"},  id_exc_val,           m_val);
    endtask

    task automatic step(input string where);
        @(posedge clk);
        m_edge();
        #1;
        check_all(where);
    endtask

    task automatic idle_inputs();
        stall_i = 0; redirect_en = 0; redirect_pc = 0; trap_en = 0; trap_pc = 0;
        imem_exc_en = 0; imem_exc_code = 0; imem_exc_val = 0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        m_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1;

        step("fetch0");
        chk("fetch0 instr lit", {32'd0, id_instr}, 64'h0050_0093);
        step("fetch4");
        chk("fetch4 instr lit", {32'd0, id_instr}, 64'h00a0_0113);
        chk("fetch4 pc lit", pc_addr, 64'd8);

        stall_i = 1;
        repeat (3) step("stall");
        chk("stall pc lit", pc_addr, 64'd8);
        stall_i = 0;
        step("resume");
        chk("resume id_pc lit", id_pc, 64'd8);

        stall_i = 1; redirect_en = 1; redirect_pc = 64'h40;
        step("redir40");
        chk("redir40 pc lit", pc_addr, 64'h40);
        stall_i = 0; redirect_en = 0;
        step("after40");
        chk("after40 id_pc lit", id_pc, 64'h40);

        redirect_en = 1; redirect_pc = 64'h42;
        step("redir42");
        redirect_en = 0;
        step("misal fault");
        chk("misal val lit", id_exc_val, 64'h42);
        step("misal bubble");
        redirect_en = 1; redirect_pc = 64'h80;   // ignored while parked
        step("parked redir");
        redirect_en = 0;
        step("parked");
        trap_en = 1; trap_pc = 64'h103;
        step("trap100");
        chk("trap pc lit", pc_addr, 64'h100);
        trap_en = 0;
        step("run100");

        redirect_en = 1; redirect_pc = 64'h2000;
        step("redir2000");
        redirect_en = 0;
        imem_exc_en = 1; imem_exc_code = 4'd1; imem_exc_val = 64'h2000;
        step("access fault");
        imem_exc_en = 0;
        stall_i = 1;
        step("fault held");
        stall_i = 0;
        step("fault bubble");
        step("fault bubble2");
        chk("fault pc lit", pc_addr, 64'h2000);

        trap_en = 1; trap_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        step("trap wrap");
        trap_en = 0;
        repeat (3) step("wrap");

        trap_en = 1; trap_pc = 64'h40;
        step("trap40");
        trap_en = 0;
        step("run44");
        step("run48");
        #3 rst_n = 0;
        #1;
        m_reset();
        check_all("async reset");
        #2 rst_n = 1;
        step("post reset");

        for (int i = 0; i < 500; i++) begin
            trap_en     = ($urandom_range(0, 19) == 0);
            trap_pc     = {32'd0, $urandom};
            redirect_en = ($urandom_range(0, 7) == 0);
            redirect_pc = {32'd0, $urandom & 32'hFFFF_FFFC} | (($urandom_range(0, 3) == 0) ? 64'($urandom_range(1, 3)) : 64'd0);
            stall_i     = ($urandom_range(0, 3) == 0);
            imem_exc_en = ($urandom_range(0, 9) == 0);
            imem_exc_code = 4'($urandom_range(0, 15));
            imem_exc_val  = {$urandom, $urandom};
            step("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
